// File: rtl/debug_display_scanner.sv
// debug_display_scanner
// Picks one of NUM_CH probe channels and drives a registered hex display word.
// Three scan modes: manual select, auto-scan with a programmable dwell, and
// single-step on a rising edge of step. Also provides freeze (snapshot),
// an enable override and an out-of-range flag.
module debug_display_scanner #(
   parameter int                NUM_CH       = 16,
   parameter int                DATA_W       = 32,
   parameter int                SEL_W        = 4,
   parameter int                DWELL_CYCLES = 50000000,
   parameter logic [DATA_W-1:0] IDLE_PATTERN = DATA_W'(32'h0000F0F0)
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable_n,
   input  logic [1:0]               mode,
   input  logic [SEL_W-1:0]         select,
   input  logic                     step,
   input  logic                     freeze,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   output logic [DATA_W-1:0]        hex_display,
   output logic [SEL_W-1:0]         cur_channel,
   output logic                     sel_err,
   output logic                     ch_change
);

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_AUTO   = 2'b01,
      MODE_STEP   = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   localparam int                NUM_SLOTS = 2 ** SEL_W;
   localparam int                CNT_W     = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [SEL_W-1:0]  CH_LAST   = SEL_W'(NUM_CH - 1);

   // Every encodable index gets a slot; indices past NUM_CH read the idle word
   // and are marked invalid so the error flag needs no magnitude compare.
   logic [DATA_W-1:0] slot_data  [NUM_SLOTS];
   logic              slot_valid [NUM_SLOTS];

   for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_slot
      if (k < NUM_CH) begin : g_live
         assign slot_data[k]  = ch_data[k*DATA_W +: DATA_W];
         assign slot_valid[k] = 1'b1;
      end else begin : g_idle
         assign slot_data[k]  = IDLE_PATTERN;
         assign slot_valid[k] = 1'b0;
      end
   end

   logic [DATA_W-1:0] hex_q, hex_d;
   logic [SEL_W-1:0]  cur_q, cur_d;
   logic              err_q, err_d;
   logic              chg_q, chg_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              step_q;

   mode_t             mode_s;
   logic [SEL_W-1:0]  next_ch_s;
   logic              step_rise_s;

   assign mode_s      = mode_t'(mode);
   // Out-of-range indices also wrap to channel 0 on the next advance.
   assign next_ch_s   = (cur_q >= CH_LAST) ? '0 : cur_q + SEL_W'(1);
   assign step_rise_s = step & ~step_q;

   // Next-state selection: enable override, then freeze, then the scan mode.
   always_comb begin
      cur_d = cur_q;
      cnt_d = cnt_q;
      hex_d = hex_q;
      err_d = err_q;
      if (enable_n) begin
         cnt_d = '0;
         hex_d = IDLE_PATTERN;
         err_d = 1'b0;
      end else if (freeze) begin
         cnt_d = cnt_q;
      end else begin
         case (mode_s)
            MODE_AUTO: begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  cur_d = next_ch_s;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            MODE_STEP: begin
               cnt_d = '0;
               if (step_rise_s) begin
                  cur_d = next_ch_s;
               end else begin
                  cur_d = cur_q;
               end
            end
            MODE_MANUAL, MODE_RSVD: begin
               cnt_d = '0;
               cur_d = select;
            end
            default: begin
               cnt_d = '0;
               cur_d = select;
            end
         endcase
         // Display follows the index being registered on this edge, never the old one.
         hex_d = slot_data[cur_d];
         err_d = ~slot_valid[cur_d];
      end
      chg_d = (cur_d != cur_q);
   end

   // State and output registers; the step history always tracks the input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hex_q  <= IDLE_PATTERN;
         cur_q  <= '0;
         err_q  <= 1'b0;
         chg_q  <= 1'b0;
         cnt_q  <= '0;
         step_q <= 1'b0;
      end else begin
         hex_q  <= hex_d;
         cur_q  <= cur_d;
         err_q  <= err_d;
         chg_q  <= chg_d;
         cnt_q  <= cnt_d;
         step_q <= step;
      end
   end

   assign hex_display = hex_q;
   assign cur_channel = cur_q;
   assign sel_err     = err_q;
   assign ch_change   = chg_q;

endmodule

// File: tb/tb_debug_display_scanner.sv
// Directed bench for debug_display_scanner with a scoreboard queue:
// each step pushes the outputs expected after the next clock edge, and the
// entry is popped and checked 1 ns after that edge.
module tb_debug_display_scanner;

   localparam int          NUM_CH = 4;
   localparam int          DATA_W = 32;
   localparam int          SEL_W  = 3;
   localparam int          DWELL  = 3;
   localparam logic [31:0] IDLE   = 32'h0000F0F0;

   logic                     clock;
   logic                     reset;
   logic                     enable_n;
   logic [1:0]               mode;
   logic [SEL_W-1:0]         select;
   logic                     step;
   logic                     freeze;
   logic [NUM_CH*DATA_W-1:0] ch_data;
   logic [DATA_W-1:0]        hex_display;
   logic [SEL_W-1:0]         cur_channel;
   logic                     sel_err;
   logic                     ch_change;

   debug_display_scanner #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .SEL_W(SEL_W),
      .DWELL_CYCLES(DWELL), .IDLE_PATTERN(IDLE)
   ) dut (
      .clock(clock), .reset(reset), .enable_n(enable_n), .mode(mode),
      .select(select), .step(step), .freeze(freeze), .ch_data(ch_data),
      .hex_display(hex_display), .cur_channel(cur_channel),
      .sel_err(sel_err), .ch_change(ch_change)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [31:0] hex;
      logic [2:0]  cur;
      logic        err;
      logic        chg;
      string       tag;
   } exp_t;

   exp_t sb[$];
   int   n_assert = 0;
   int   n_fail   = 0;

   function automatic logic [31:0] chv(input int k);
      return 32'hA000_0000 + 32'(k);
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", name, obs, exp);
      end
   endtask

   task automatic push(input logic [31:0] h, input int c, input logic e, input logic g, input string t);
      exp_t x;
      x.hex = h;
      x.cur = 3'(c);
      x.err = e;
      x.chg = g;
      x.tag = t;
      sb.push_back(x);
   endtask

   task automatic expect_now();
      exp_t x;
      n_assert++;
      assert (sb.size() != 0)
      else begin
         n_fail++;
         $error("FAIL scoreboard: observed empty queue expected an entry");
      end
      if (sb.size() != 0) begin
         x = sb.pop_front();
         chk({x.tag, ".hex"}, hex_display, x.hex);
         chk({x.tag, ".cur"}, {29'b0, cur_channel}, {29'b0, x.cur});
         chk({x.tag, ".err"}, {31'b0, sel_err}, {31'b0, x.err});
         chk({x.tag, ".chg"}, {31'b0, ch_change}, {31'b0, x.chg});
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #1;
      expect_now();
   endtask

   initial begin
      int c;
      int tgt;
      logic [31:0] h;

      reset    = 1'b0;
      enable_n = 1'b0;
      mode     = 2'b00;
      select   = '0;
      step     = 1'b0;
      freeze   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) ch_data[k*DATA_W +: DATA_W] = chv(k);
      #1 reset = 1'b1;
      #1;
      push(IDLE, 0, 1'b0, 1'b0, "reset");
      expect_now();
      @(posedge clock);
      #1 reset = 1'b0;

      // MANUAL select, out-of-range select, reserved mode
      select = 3'd2;
      push(chv(2), 2, 1'b0, 1'b1, "man_sel2");  cycle();
      push(chv(2), 2, 1'b0, 1'b0, "man_hold");  cycle();
      select = 3'd5;
      push(IDLE, 5, 1'b1, 1'b1, "man_oor");     cycle();
      mode = 2'b11; select = 3'd2;
      push(chv(2), 2, 1'b0, 1'b1, "rsvd_sel2"); cycle();
      mode = 2'b00; select = 3'd0;
      push(chv(0), 0, 1'b0, 1'b1, "man_sel0");  cycle();

      // AUTO wrap sequence with a live probe change mid-dwell on channel 1
      mode = 2'b01;
      for (int i = 1; i <= 12; i++) begin
         if (i == 5) ch_data[1*DATA_W +: DATA_W] = 32'h12345678;
         c = (i / 3) % 4;
         h = (c == 1 && i == 5) ? 32'h12345678 : chv(c);
         push(h, c, 1'b0, (i % 3) == 0, "auto_seq");
         cycle();
      end
      ch_data[1*DATA_W +: DATA_W] = chv(1);

      // STEP: held-high step advances once, then three single pulses
      mode = 2'b10;
      step = 1'b1;
      for (int i = 0; i < 10; i++) begin
         push(chv(1), 1, 1'b0, i == 0, "step_held");
         cycle();
      end
      step = 1'b0;
      push(chv(1), 1, 1'b0, 1'b0, "step_low"); cycle();
      for (int p = 0; p < 3; p++) begin
         tgt = (p == 0) ? 2 : ((p == 1) ? 3 : 0);
         step = 1'b1;
         push(chv(tgt), tgt, 1'b0, 1'b1, "step_pulse"); cycle();
         step = 1'b0;
         push(chv(tgt), tgt, 1'b0, 1'b0, "step_rest");  cycle();
      end

      // STEP edge under freeze is discarded, and release gives no false edge
      freeze = 1'b1;
      push(chv(0), 0, 1'b0, 1'b0, "frz_step0"); cycle();
      step = 1'b1;
      push(chv(0), 0, 1'b0, 1'b0, "frz_edge");  cycle();
      push(chv(0), 0, 1'b0, 1'b0, "frz_edge2"); cycle();
      freeze = 1'b0;
      push(chv(0), 0, 1'b0, 1'b0, "frz_rel");   cycle();
      step = 1'b0;
      push(chv(0), 0, 1'b0, 1'b0, "frz_low");   cycle();

      // AUTO up to channel 2 with dwell count 1, then freeze for 20 cycles
      mode = 2'b01;
      for (int i = 1; i <= 7; i++) begin
         c = i / 3;
         push(chv(c), c, 1'b0, (i % 3) == 0, "auto_to2");
         cycle();
      end
      freeze = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (i == 5)  ch_data[2*DATA_W +: DATA_W] = 32'hDEADBEEF;
         if (i == 19) ch_data[2*DATA_W +: DATA_W] = chv(2);
         push(chv(2), 2, 1'b0, 1'b0, "frz_auto");
         cycle();
      end
      freeze = 1'b0;
      push(chv(2), 2, 1'b0, 1'b0, "unfrz1"); cycle();
      push(chv(3), 3, 1'b0, 1'b1, "unfrz2"); cycle();

      // enable_n overrides freeze; re-enable shows the retained channel
      freeze = 1'b1; enable_n = 1'b1;
      push(IDLE, 3, 1'b0, 1'b0, "dis1"); cycle();
      push(IDLE, 3, 1'b0, 1'b0, "dis2"); cycle();
      enable_n = 1'b0; freeze = 1'b0;
      push(chv(3), 3, 1'b0, 1'b0, "reen"); cycle();

      // Asynchronous reset between edges, mid-dwell at channel 3
      #2 reset = 1'b1;
      #1;
      push(IDLE, 0, 1'b0, 1'b0, "async_rst");
      expect_now();
      reset = 1'b0;
      push(chv(0), 0, 1'b0, 1'b0, "post_rst1"); cycle();
      push(chv(0), 0, 1'b0, 1'b0, "post_rst2"); cycle();
      push(chv(1), 1, 1'b0, 1'b1, "post_rst3"); cycle();

      // Out-of-range index: error cleared while disabled, AUTO advance goes to 0
      mode = 2'b00; select = 3'd5;
      push(IDLE, 5, 1'b1, 1'b1, "oor_man"); cycle();
      enable_n = 1'b1;
      push(IDLE, 5, 1'b0, 1'b0, "oor_dis"); cycle();
      enable_n = 1'b0; mode = 2'b01;
      push(IDLE, 5, 1'b1, 1'b0, "oor_auto1"); cycle();
      push(IDLE, 5, 1'b1, 1'b0, "oor_auto2"); cycle();
      push(chv(0), 0, 1'b0, 1'b1, "oor_wrap"); cycle();

      n_assert++;
      assert (sb.size() == 0)
      else begin
         n_fail++;
         $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/debug_display_scanner.md
Name: debug_display_scanner

Overview:
- Parametrised successor to the processor's debug display mux.
- Selects one of NUM_CH DATA_W-bit probe channels (register-file addresses, PC, IR, RA, RB, RZ, RM, RY, ...) and drives the registered hex display word.
- Adds three modes: manual select, auto-scan with a programmable dwell time, and single-step on a button edge. Also adds a freeze (snapshot) function and a range-error flag.
- Sits between the datapath probe taps and the seven-segment hex driver.

Parameters:
- NUM_CH, 16, number of probe channels (2..256).
- DATA_W, 32, width of each channel and of the display word.
- SEL_W, 4, channel index width; must satisfy 2**SEL_W >= NUM_CH.
- DWELL_CYCLES, 50000000, clocks per channel in auto-scan (>= 1).
- IDLE_PATTERN, 32'h0000F0F0, word shown when disabled or out of range (low DATA_W bits are used).

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high reset.
- enable_n, input, 1, active-low display enable; 1 forces IDLE_PATTERN.
- mode, input, 2, 00 = MANUAL, 01 = AUTO, 10 = STEP, 11 = reserved (treated as MANUAL).
- select, input, SEL_W, channel index used in MANUAL.
- step, input, 1, level input, already synchronised; each rising edge advances one channel in STEP.
- freeze, input, 1, holds the display word and all scan state while high.
- ch_data, input, NUM_CH*DATA_W, flattened channels; channel k occupies bits [k*DATA_W +: DATA_W].
- hex_display, output, DATA_W, registered display word.
- cur_channel, output, SEL_W, registered index currently displayed.
- sel_err, output, 1, registered; 1 when the displayed index is >= NUM_CH.
- ch_change, output, 1, one-cycle pulse when cur_channel changes value.

Behaviour:
- Reset (asynchronous, any time including mid-dwell):
  - hex_display = IDLE_PATTERN, cur_channel = 0, sel_err = 0, ch_change = 0.
  - Dwell counter = 0, step edge register = 0.
- Update priority each clock, highest first: enable_n, then freeze, then mode logic.
- enable_n = 1:
  - hex_display = IDLE_PATTERN next cycle.
  - cur_channel holds; dwell counter cleared; ch_change = 0.
  - freeze is ignored.
- freeze = 1 (and enabled):
  - hex_display, cur_channel, sel_err and the dwell counter all hold; ch_change = 0.
  - Step edges during freeze are discarded, but the edge register keeps tracking step, so releasing freeze does not create a false edge.
- MANUAL:
  - cur_channel <= select.
  - hex_display <= ch_data[select], or IDLE_PATTERN with sel_err = 1 if select >= NUM_CH.
  - Latency: 1 clock from select or ch_data change to hex_display.
- AUTO:
  - Dwell counter counts 0..DWELL_CYCLES-1.
  - At terminal count, the counter goes to 0 and cur_channel advances by 1, wrapping from NUM_CH-1 to 0.
  - If cur_channel is out of range on entry, the next advance goes to 0.
  - hex_display tracks ch_data[cur_channel] live every cycle (1-clock latency), so a changing probe value is visible during the dwell.
  - DWELL_CYCLES = 1 advances every clock.
- STEP:
  - A rising edge of step (step = 1 while the previous sampled value was 0) advances cur_channel with the same wrap rule; hex_display is live as in AUTO.
  - A held-high step advances exactly once.
- Mode change: the dwell counter is cleared on the first cycle in the new mode; cur_channel is retained.
- Display word: hex_display always reflects the cur_channel value being registered in the same edge; the output is never one index stale.
- ch_change: asserted in the cycle after cur_channel's registered value differs from its previous value (MANUAL select change, AUTO advance, STEP advance).
- sel_err: valid in all modes; 0 while enable_n = 1.
- Counter width: the dwell counter is ceil(log2(DWELL_CYCLES)) bits, minimum 1; it must not overflow for any legal parameter.

Test Plan (NUM_CH = 4, DATA_W = 32, SEL_W = 3, DWELL_CYCLES = 3, channel k = 32'hA000_0000 + k):
- Reset then MANUAL: select = 2 -> one clock later hex_display = 32'hA0000002, cur_channel = 2, ch_change pulses 1 cycle. Then select = 5 -> hex_display = 32'h0000F0F0, sel_err = 1.
- AUTO from cur_channel = 0: cur_channel sequence 0,0,0,1,1,1,2,2,2,3,3,3,0 on successive clocks (wrap). Change ch_data[1] mid-dwell to 32'h12345678 -> hex_display shows it on the next clock.
- STEP: step held high for 10 cycles -> exactly one advance 0 -> 1. Two separate pulses -> 1 -> 3; third pulse -> 0.
- freeze asserted in AUTO at cur_channel = 2, count 1, for 20 cycles -> all outputs constant. Release -> advance to 3 occurs 2 clocks later. Step edge during freeze in STEP -> no advance.
- enable_n = 1 with freeze = 1 -> hex_display = 32'h0000F0F0, sel_err = 0. enable_n back to 0 -> previous cur_channel shown on the next clock.
- Assert reset asynchronously mid-dwell (between clock edges) at cur_channel = 3 -> outputs are immediately IDLE_PATTERN and channel 0. After release in AUTO, the first advance occurs after 3 clocks.
